// File: rtl/univ_shift_reg.sv
// Universal shift register with configurable width/step, hold/shift/rotate/ASR/load
// modes and a frame counter that pulses done after every WIDTH/STEP shift ops.
module univ_shift_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [2:0]                    mode,
    input  logic [STEP-1:0]               sin_r,
    input  logic [STEP-1:0]               sin_l,
    input  logic [WIDTH-1:0]              pdata,
    output logic [WIDTH-1:0]              q,
    output logic [STEP-1:0]               sout_r,
    output logic [STEP-1:0]               sout_l,
    output logic [$clog2(WIDTH/STEP):0]   cnt,
    output logic                          done
);

    localparam int unsigned N  = WIDTH / STEP;
    localparam int unsigned CW = $clog2(N) + 1;

    typedef enum logic [2:0] {
        M_HOLD = 3'b000,
        M_SHR  = 3'b001,
        M_SHL  = 3'b010,
        M_ROR  = 3'b011,
        M_ROL  = 3'b100,
        M_LOAD = 3'b101,
        M_ASR  = 3'b110,
        M_RSV  = 3'b111
    } mode_t;

    mode_t            op;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             done_nxt;
    logic             shift_op;

    assign op     = mode_t'(mode);
    assign sout_r = q[STEP-1:0];
    assign sout_l = q[WIDTH-1:WIDTH-STEP];

    // Next register contents and frame bookkeeping for an enabled edge
    always_comb begin
        q_nxt    = q;
        cnt_nxt  = cnt;
        done_nxt = 1'b0;
        shift_op = 1'b0;
        case (op)
            M_SHR:   begin q_nxt = {sin_r, q[WIDTH-1:STEP]};                     shift_op = 1'b1; end
            M_SHL:   begin q_nxt = {q[WIDTH-STEP-1:0], sin_l};                   shift_op = 1'b1; end
            M_ROR:   begin q_nxt = {q[STEP-1:0], q[WIDTH-1:STEP]};               shift_op = 1'b1; end
            M_ROL:   begin q_nxt = {q[WIDTH-STEP-1:0], q[WIDTH-1:WIDTH-STEP]};   shift_op = 1'b1; end
            M_ASR:   begin q_nxt = {{STEP{q[WIDTH-1]}}, q[WIDTH-1:STEP]};        shift_op = 1'b1; end
            M_LOAD:  begin q_nxt = pdata; cnt_nxt = '0; end
            default: begin q_nxt = q; end
        endcase
        // Frame wrap: the N-th shift op returns cnt to zero and fires done
        if (shift_op) begin
            if (cnt == CW'(N - 1)) begin
                cnt_nxt  = '0;
                done_nxt = 1'b1;
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            cnt  <= '0;
            done <= 1'b0;
        end else if (!en) begin
            done <= 1'b0;
        end else begin
            q    <= q_nxt;
            cnt  <= cnt_nxt;
            done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios plus randomized traffic on a
// STEP=1 and a STEP=4 instance, checked against an arithmetic reference model.
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;

    logic       a_en, a_sinr, a_sinl, a_soutr, a_soutl, a_done;
    logic [2:0] a_mode;
    logic [7:0] a_pd, a_q;
    logic [3:0] a_cnt;

    logic       b_en, b_done;
    logic [2:0] b_mode;
    logic [3:0] b_sinr, b_sinl, b_soutr, b_soutl;
    logic [7:0] b_pd, b_q;
    logic [1:0] b_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] m_q [2];
    int         m_cnt [2];
    logic       m_done [2];

    univ_shift_reg #(.WIDTH(8), .STEP(1)) dut_a (
        .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .sin_r(a_sinr), .sin_l(a_sinl),
        .pdata(a_pd), .q(a_q), .sout_r(a_soutr), .sout_l(a_soutl), .cnt(a_cnt), .done(a_done));

    univ_shift_reg #(.WIDTH(8), .STEP(4)) dut_b (
        .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .sin_r(b_sinr), .sin_l(b_sinl),
        .pdata(b_pd), .q(b_q), .sout_r(b_soutr), .sout_l(b_soutl), .cnt(b_cnt), .done(b_done));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: register as an integer, shifts as arithmetic, frame as op count mod N
    task automatic model_apply(input int i, input int step, input logic r, input logic e,
                               input logic [2:0] md, input logic [3:0] sr, input logic [3:0] sl,
                               input logic [7:0] pd);
        int v;
        int s;
        bit shift;
        v = int'(m_q[i]);
        shift = 0;
        if (r) begin
            m_q[i] = 8'h00; m_cnt[i] = 0; m_done[i] = 1'b0;
            return;
        end
        if (!e) begin
            m_done[i] = 1'b0;
            return;
        end
        case (md)
            3'd1: begin v = (v >> step) | (int'(sr) << (8 - step)); shift = 1; end
            3'd2: begin v = (v << step) | int'(sl); shift = 1; end
            3'd3: begin v = (v >> step) | (v << (8 - step)); shift = 1; end
            3'd4: begin v = (v << step) | (v >> (8 - step)); shift = 1; end
            3'd5: begin v = int'(pd); m_cnt[i] = 0; end
            3'd6: begin s = v[7] ? (v | 32'hFFFF_FF00) : v; v = s >>> step; shift = 1; end
            default: ;
        endcase
        m_q[i] = 8'(v & 32'hFF);
        m_done[i] = 1'b0;
        if (shift) begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == 8 / step) begin
                m_cnt[i] = 0;
                m_done[i] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_apply(0, 1, rst, a_en, a_mode, {3'b000, a_sinr}, {3'b000, a_sinl}, a_pd);
        model_apply(1, 4, rst, b_en, b_mode, b_sinr, b_sinl, b_pd);
        #1;
    endtask

    task automatic drive_a(input logic e, input logic [2:0] md, input logic sr, input logic sl,
                           input logic [7:0] pd);
        a_en = e; a_mode = md; a_sinr = sr; a_sinl = sl; a_pd = pd;
    endtask

    task automatic drive_b(input logic e, input logic [2:0] md, input logic [3:0] sr,
                           input logic [3:0] sl, input logic [7:0] pd);
        b_en = e; b_mode = md; b_sinr = sr; b_sinl = sl; b_pd = pd;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_a(1'b1, 3'd5, 1'b1, 1'b1, 8'hFF);
        drive_b(1'b1, 3'd5, 4'hF, 4'hF, 8'hFF);
        tick(); tick();
        n_tests++; if (a_q !== 8'h00) begin n_fail++; $display("FAIL reset_a_q got %h want 00", a_q); end
        n_tests++; if (a_cnt !== 4'd0 || a_done !== 1'b0) begin n_fail++; $display("FAIL reset_a_cnt_done got %0d/%b want 0/0", a_cnt, a_done); end
        n_tests++; if (a_soutr !== 1'b0 || a_soutl !== 1'b0) begin n_fail++; $display("FAIL reset_a_sout got %b/%b want 0/0", a_soutr, a_soutl); end
        n_tests++; if (b_q !== 8'h00 || b_cnt !== 2'd0 || b_done !== 1'b0) begin n_fail++; $display("FAIL reset_b got q=%h cnt=%0d done=%b want 00/0/0", b_q, b_cnt, b_done); end
        rst = 1'b0;
        drive_a(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        drive_b(1'b0, 3'd0, 4'h0, 4'h0, 8'h00);
        tick();
    endtask

    task automatic test_serialize();
        logic [7:0] exp_bits;
        exp_bits = 8'b1011_0100;
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'hB4);
        tick();
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (a_soutr !== exp_bits[i]) begin n_fail++; $display("FAIL ser_sout_r[%0d] got %b want %b", i, a_soutr, exp_bits[i]); end
            n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL ser_early_done[%0d] got %b want 0", i, a_done); end
            drive_a(1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
            tick();
        end
        n_tests++; if (a_done !== 1'b1) begin n_fail++; $display("FAIL ser_done got %b want 1", a_done); end
        n_tests++; if (a_q !== 8'h00 || a_cnt !== 4'd0) begin n_fail++; $display("FAIL ser_end got q=%h cnt=%0d want 00/0", a_q, a_cnt); end
        drive_a(1'b1, 3'd0, 1'b0, 1'b0, 8'h00);
        tick();
        n_tests++; if (a_done !== 1'b0) begin n_fail++; $display("FAIL ser_done_width got %b want 0", a_done); end
    endtask

    task automatic test_rotate_asr();
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h81); tick();
        drive_a(1'b1, 3'd4, 1'b0, 1'b0, 8'h00); tick();
        n_tests++; if (a_q !== 8'h03) begin n_fail++; $display("FAIL rol got %h want 03", a_q); end
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h81); tick();
        drive_a(1'b1, 3'd3, 1'b0, 1'b0, 8'h00); tick();
        n_tests++; if (a_q !== 8'hC0) begin n_fail++; $display("FAIL ror got %h want c0", a_q); end
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h80); tick();
        drive_a(1'b1, 3'd6, 1'b0, 1'b0, 8'h00);
        tick(); tick(); tick();
        n_tests++; if (a_q !== 8'hF0) begin n_fail++; $display("FAIL asr3 got %h want f0", a_q); end
        n_tests++; if (a_soutl !== 1'b1) begin n_fail++; $display("FAIL asr_sout_l got %b want 1", a_soutl); end
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h81); tick();
        drive_a(1'b1, 3'd2, 1'b0, 1'b1, 8'h00); tick();
        n_tests++; if (a_q !== 8'h03 || a_cnt !== 4'd1) begin n_fail++; $display("FAIL shl got q=%h cnt=%0d want 03/1", a_q, a_cnt); end
        drive_a(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_multistep();
        drive_b(1'b1, 3'd5, 4'h0, 4'h0, 8'h3C); tick();
        n_tests++; if (b_soutr !== 4'hC) begin n_fail++; $display("FAIL step4_load_sout got %h want c", b_soutr); end
        drive_b(1'b1, 3'd1, 4'hA, 4'h0, 8'h00); tick();
        n_tests++; if (b_q !== 8'hA3 || b_soutr !== 4'h3 || b_cnt !== 2'd1 || b_done !== 1'b0) begin
            n_fail++; $display("FAIL step4_shift1 got q=%h sout=%h cnt=%0d done=%b want a3/3/1/0", b_q, b_soutr, b_cnt, b_done); end
        drive_b(1'b1, 3'd1, 4'h5, 4'h0, 8'h00); tick();
        n_tests++; if (b_q !== 8'h5A || b_done !== 1'b1 || b_cnt !== 2'd0) begin
            n_fail++; $display("FAIL step4_shift2 got q=%h cnt=%0d done=%b want 5a/0/1", b_q, b_cnt, b_done); end
        n_tests++; if (b_soutl !== 4'h5) begin n_fail++; $display("FAIL step4_sout_l got %h want 5", b_soutl); end
        drive_b(1'b0, 3'd0, 4'h0, 4'h0, 8'h00); tick();
        n_tests++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL step4_done_width got %b want 0", b_done); end
    endtask

    task automatic test_enable();
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h5A); tick();
        drive_a(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        tick(); tick(); tick();
        n_tests++; if (a_cnt !== 4'd3 || a_q !== 8'hEB) begin n_fail++; $display("FAIL en_setup got q=%h cnt=%0d want eb/3", a_q, a_cnt); end
        drive_a(1'b0, 3'd1, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (a_q !== 8'hEB || a_cnt !== 4'd3 || a_done !== 1'b0) begin
                n_fail++; $display("FAIL en_hold[%0d] got q=%h cnt=%0d done=%b want eb/3/0", i, a_q, a_cnt, a_done); end
        end
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'hFF); tick();
        n_tests++; if (a_q !== 8'hFF || a_cnt !== 4'd0 || a_done !== 1'b0) begin
            n_fail++; $display("FAIL abandon_load got q=%h cnt=%0d done=%b want ff/0/0", a_q, a_cnt, a_done); end
        drive_a(1'b1, 3'd1, 1'b0, 1'b0, 8'h00);
        for (int i = 1; i <= 8; i++) begin
            tick();
            n_tests++; if (a_done !== (i == 8)) begin n_fail++; $display("FAIL abandon_frame[%0d] got done=%b want %b", i, a_done, i == 8); end
        end
    endtask

    task automatic test_reset_midframe();
        int dones;
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'hA5); tick();
        drive_a(1'b1, 3'd1, 1'b1, 1'b0, 8'h00);
        tick(); tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++; if (a_q !== 8'h00 || a_cnt !== 4'd0 || a_done !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid got q=%h cnt=%0d done=%b want 00/0/0", a_q, a_cnt, a_done); end
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            drive_a(1'b1, 3'd1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            tick();
            if (a_done === 1'b1) dones++;
        end
        drive_a(1'b1, 3'd0, 1'b0, 1'b0, 8'h00); tick();
        if (a_done === 1'b1) dones++;
        n_tests++; if (dones != 1) begin n_fail++; $display("FAIL rst_new_frame got %0d done pulses want 1", dones); end
        n_tests++; if (a_q !== m_q[0]) begin n_fail++; $display("FAIL rst_frame_q got %h want %h", a_q, m_q[0]); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] held;
        rst = 1'b1; tick(); rst = 1'b0;
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h6D); tick();
        drive_a(1'b1, 3'd1, 1'b1, 1'b0, 8'h00); tick();
        held = a_q;
        drive_a(1'b1, 3'd7, 1'b1, 1'b1, 8'hFF);
        tick(); tick();
        n_tests++; if (a_q !== 8'hB6 || held !== 8'hB6 || a_cnt !== 4'd1 || a_done !== 1'b0) begin
            n_fail++; $display("FAIL reserved_hold got q=%h cnt=%0d done=%b want b6/1/0", a_q, a_cnt, a_done); end
        drive_a(1'b1, 3'd5, 1'b0, 1'b0, 8'h00); tick();
        for (int i = 1; i <= 24; i++) begin
            drive_a(1'b1, 3'd1, 1'($urandom_range(0, 1)), 1'b0, 8'h00);
            tick();
            n_tests++; if (a_done !== (i % 8 == 0)) begin n_fail++; $display("FAIL stream_done[%0d] got %b want %b", i, a_done, i % 8 == 0); end
            n_tests++; if (a_cnt !== 4'(i % 8)) begin n_fail++; $display("FAIL stream_cnt[%0d] got %0d want %0d", i, a_cnt, i % 8); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            drive_a(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 1'($urandom),
                    1'($urandom), 8'($urandom));
            drive_b(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 4'($urandom),
                    4'($urandom), 8'($urandom));
            tick();
            n_tests++; if (a_q !== m_q[0] || a_soutr !== m_q[0][0] || a_soutl !== m_q[0][7]) begin
                n_fail++; $display("FAIL rand_a_q[%0d] got %h want %h", c, a_q, m_q[0]); end
            n_tests++; if (a_cnt !== 4'(m_cnt[0]) || a_done !== m_done[0]) begin
                n_fail++; $display("FAIL rand_a_cnt[%0d] got %0d/%b want %0d/%b", c, a_cnt, a_done, m_cnt[0], m_done[0]); end
            n_tests++; if (b_q !== m_q[1] || b_soutr !== m_q[1][3:0] || b_soutl !== m_q[1][7:4]) begin
                n_fail++; $display("FAIL rand_b_q[%0d] got %h want %h", c, b_q, m_q[1]); end
            n_tests++; if (b_cnt !== 2'(m_cnt[1]) || b_done !== m_done[1]) begin
                n_fail++; $display("FAIL rand_b_cnt[%0d] got %0d/%b want %0d/%b", c, b_cnt, b_done, m_cnt[1], m_done[1]); end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_q[i] = 8'h00; m_cnt[i] = 0; m_done[i] = 1'b0;
        end
        rst = 1'b1;
        drive_a(1'b0, 3'd0, 1'b0, 1'b0, 8'h00);
        drive_b(1'b0, 3'd0, 4'h0, 4'h0, 8'h00);
        test_reset();
        test_serialize();
        test_rotate_asr();
        test_multistep();
        test_enable();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: the successor to our fixed 4-bit serial-in/serial-out register. It supports configurable width and shift step, and hold, shift, rotate, arithmetic-shift and parallel-load modes. A frame counter with a completion pulse lets the block act as a serializer or deserializer in front of serial links and bit-stream datapaths.

## Interface
- WIDTH, 8, register width in bits; must be ≥ 2.
- STEP, 1, bits moved per shift operation; 1 ≤ STEP < WIDTH, and WIDTH % STEP == 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high; clock clk.
- en  in  1  operation enable; 0 = hold all state.
- mode  in  3  operation select (see Operation).
- sin_r  in  STEP  serial input entering at the MSB end during shift right.
- sin_l  in  STEP  serial input entering at the LSB end during shift left.
- pdata  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- sout_r  out  STEP  q[STEP-1:0]; serial output for right shifts.
- sout_l  out  STEP  q[WIDTH-1:WIDTH-STEP]; serial output for left shifts.
- cnt  out  $clog2(WIDTH/STEP)+1  shifts completed in the current frame.
- done  out  1  one-cycle frame-complete pulse.

## Operation
- N = WIDTH/STEP is the number of shifts per frame.
- Priority at each edge: rst > en=0 > mode.
- rst=1: q=0, cnt=0, done=0. This applies regardless of en and mode, including mid-frame.
- en=0: q and cnt hold; done=0.
- mode 000, hold: q and cnt unchanged; done=0.
- mode 001, shift right: q ← {sin_r, q[WIDTH-1:STEP]}.
- mode 010, shift left: q ← {q[WIDTH-STEP-1:0], sin_l}.
- mode 011, rotate right: q ← {q[STEP-1:0], q[WIDTH-1:STEP]}.
- mode 100, rotate left: q ← {q[WIDTH-STEP-1:0], q[WIDTH-1:WIDTH-STEP]}.
- mode 101, parallel load: q ← pdata; cnt ← 0; done=0. A load mid-frame abandons the frame with no pulse.
- mode 110, arithmetic shift right: q ← {STEP copies of q[WIDTH-1], q[WIDTH-1:STEP]}. sin_r is ignored.
- mode 111: reserved; behaves exactly as hold.
- Modes 001, 010, 011, 100 and 110 are shift ops. Each shift op with en=1 increments cnt.
- Frame wrap: when cnt == N-1 and a shift op occurs, cnt ← 0 and done is asserted.
- cnt never reaches N and never exceeds N-1.
- Direction changes mid-frame are legal; cnt counts ops regardless of direction.

## Timing
- q, cnt and done are registered and update on the rising edge of clk.
- sout_r and sout_l are combinational slices of q; no extra latency.
- Reset values: q=0, cnt=0, done=0. This makes sout_r=0 and sout_l=0.
- done is high for exactly the one cycle following the edge of the N-th shift op; otherwise 0.
- done may be high on consecutive frames every N cycles under continuous shifting.
- Serial latency: a STEP-bit group presented at sin_r appears on sout_r after N shift-right edges. For WIDTH=4, STEP=1 this is 4 edges, matching the legacy 4-bit register.
- Parallel load to first serial bit: pdata[STEP-1:0] is visible on sout_r the cycle after the load edge. Each subsequent group follows one shift edge later.
- Parallel capture (deserializer use): q holds the complete frame in the same cycle that done is high.

## Test plan
1. **Serialize, WIDTH=8, STEP=1.** Load 0xB4, then apply 8 shift-right ops with sin_r=0.
   - sout_r, sampled before each shift edge, reads 0,0,1,0,1,1,0,1.
   - done=1 for one cycle after the 8th edge; q=0x00, cnt=0.
2. **Rotate and arithmetic shift, WIDTH=8.**
   - Rotate left 0x81 → 0x03; rotate right 0x81 → 0xC0.
   - Three ASR ops on 0x80 → 0xF0.
   - Shift left on 0x81 with sin_l=1 → 0x03.
3. **Multi-bit step, WIDTH=8, STEP=4.** Load 0x3C; sout_r=0xC.
   - Shift right with sin_r=0xA → q=0xA3, sout_r=0x3, cnt=1.
   - Second shift with sin_r=0x5 → q=0x5A, done=1 next cycle, cnt=0.
4. **Enable gating and frame abandon.** From cnt=3 with mode=001 and en=0 for 5 cycles: q and cnt unchanged, done=0. Then load 0xFF with en=1: q=0xFF, cnt=0, no done pulse.
5. **Reset mid-frame.** After load 0xA5 and 3 shifts, assert rst together with en=1, mode=001: next cycle q=0x00, cnt=0, done=0. A new 8-shift frame then produces done exactly once.
6. **Reserved mode and continuous streaming.** mode=111 behaves as hold. 24 back-to-back shift-right ops (WIDTH=8, STEP=1) produce done pulses after edges 8, 16 and 24 only.
